// File: rtl/svm_decision_unit.sv
// svm_decision_unit: accumulates alpha-weighted linear/quadratic kernel terms over NUM_SV support vectors and emits the SVM decision.
module svm_decision_unit #(
  parameter int DATA_SIZE  = 32,
  parameter int ACCUM_SIZE = 64,
  parameter int NUM_SV     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dot_valid,
  output logic                         dot_ready,
  input  logic signed [ACCUM_SIZE-1:0] dot_in,
  input  logic signed [DATA_SIZE-1:0]  alpha_in,
  input  logic                         kernel_sel,
  input  logic signed [ACCUM_SIZE-1:0] bias,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic signed [ACCUM_SIZE-1:0] decision,
  output logic                         class_out
);
  localparam int CW = $clog2(NUM_SV + 1);
  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic signed [ACCUM_SIZE-1:0] k_r, p_r, sum, dot_p1, k_next, alpha_ext;
  logic signed [DATA_SIZE-1:0] alpha_r;
  logic v1, v2, accept;
  assign dot_ready = state == ACCUM;
  assign accept    = dot_valid & dot_ready;
  assign class_out = ~decision[ACCUM_SIZE-1];
  assign dot_p1    = dot_in + 1'b1;
  // products keep only the low ACCUM_SIZE bits, which is identical for signed and unsigned operands
  assign k_next    = kernel_sel ? dot_p1 * dot_p1 : dot_in;
  assign alpha_ext = {{(ACCUM_SIZE-DATA_SIZE){alpha_r[DATA_SIZE-1]}}, alpha_r};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      count        <= '0;
      sum          <= '0;
      k_r          <= '0;
      p_r          <= '0;
      alpha_r      <= '0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      decision     <= '0;
      result_valid <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        k_r     <= k_next;
        alpha_r <= alpha_in;
      end
      if (v1) p_r <= k_r * alpha_ext;
      if (v2) sum <= sum + p_r;
      case (state)
        ACCUM: if (accept) begin
          count <= count + 1'b1;
          if (count == CW'(NUM_SV - 1)) state <= DRAIN;
        end
        DRAIN: if (!v1 && !v2) begin
          decision     <= sum + bias;
          result_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: if (result_ready) begin
          result_valid <= 1'b0;
          sum          <= '0;
          count        <= '0;
          state        <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_svm_decision_unit.sv
// tb_svm_decision_unit: random and directed classifications scored against an arithmetic reference model.
module tb_svm_decision_unit;
  logic clk, rst, dot_valid, dot_ready, kernel_sel, result_valid, result_ready, class_out;
  logic signed [63:0] dot_in, bias, decision;
  logic signed [31:0] alpha_in;
  int n_vec = 0, n_err = 0;
  longint expq[$];
  bit force_low = 0;
  longint dv[4];
  int av[4];
  bit kv[4];
  bit prev_v, prev_hs, hs;
  logic [63:0] prev_d;
  longint e;

  svm_decision_unit dut (
    .clk(clk), .rst(rst), .dot_valid(dot_valid), .dot_ready(dot_ready),
    .dot_in(dot_in), .alpha_in(alpha_in), .kernel_sel(kernel_sel), .bias(bias),
    .result_valid(result_valid), .result_ready(result_ready),
    .decision(decision), .class_out(class_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur, expected it within bound", nm);
  endtask

  function automatic longint model(input longint d[4], input int a[4], input bit k[4], input longint b);
    longint s, kk;
    s = b;
    for (int i = 0; i < 4; i++) begin
      kk = k[i] ? (d[i] + 1) * (d[i] + 1) : d[i];
      s += kk * longint'(a[i]);
    end
    return s;
  endfunction

  task automatic run_class(input longint d[4], input int a[4], input bit k[4], input longint b,
                           input int n, input int maxgap, input bit push);
    int w;
    bit rdy;
    w = 0;
    while (!dot_ready && w < 300) begin
      @(posedge clk); #1; w++;
    end
    if (!dot_ready) fail_now("wait_accum");
    if (push) expq.push_back(model(d, a, k, b));
    bias = b;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        dot_valid = 0;
        @(posedge clk); #1;
      end
      dot_valid = 1; dot_in = d[i]; alpha_in = a[i]; kernel_sel = k[i];
      w = 0;
      do begin
        @(negedge clk); rdy = dot_ready;
        @(posedge clk); #1; w++;
      end while (!rdy && w < 300);
      if (!rdy) fail_now("accept");
    end
    dot_valid = 0;
  endtask

  initial begin
    result_ready = 0;
    forever begin
      @(posedge clk); #2;
      result_ready = force_low ? 1'b0 : ($urandom_range(3, 0) != 0);
    end
  end

  // scoreboard monitor: holds must persist until the handshake, each handshake pops one expectation
  initial begin
    prev_v = 0; prev_hs = 0; prev_d = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_v = 0;
      else begin
        if (prev_v && !prev_hs) begin
          chk("hold_valid", result_valid, 1);
          chk("hold_decision", decision, prev_d);
        end
        hs = result_valid && result_ready;
        if (hs) begin
          if (expq.size() == 0) fail_now("expected_entry_for_result");
          else begin
            e = expq.pop_front();
            chk("decision", decision, e);
            chk("class_out", class_out, e >= 0);
          end
        end
        prev_v = result_valid; prev_hs = hs; prev_d = decision;
      end
    end
  end

  initial begin
    int w;
    rst = 1; dot_valid = 0; dot_in = 0; alpha_in = 0; kernel_sel = 0; bias = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result_valid", result_valid, 0);
    chk("rst_decision", decision, 0);
    chk("rst_class_out", class_out, 1);
    chk("rst_dot_ready", dot_ready, 1);
    rst = 0;
    @(posedge clk); #1;

    dv = '{1, 2, 3, 4}; av = '{1, -1, 2, 1}; kv = '{0, 0, 0, 0};
    run_class(dv, av, kv, -5, 4, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_edge%0d", i), result_valid, i == 3);
    end
    chk("linear_decision", decision, 4);

    dv = '{1, 0, -1, 2}; av = '{1, 1, 1, 1}; kv = '{1, 1, 1, 1};
    run_class(dv, av, kv, 0, 4, 0, 1);
    dv = '{5, 5, 5, 5}; av = '{-1, -1, -1, -1}; kv = '{0, 0, 0, 0};
    run_class(dv, av, kv, 3, 4, 1, 1);
    dv = '{64'sd4294967296, -1, -1, -1}; av = '{1, 1, 1, 1}; kv = '{1, 1, 1, 1};
    run_class(dv, av, kv, 0, 4, 0, 1);

    w = 0;
    while (!dot_ready && w < 300) begin @(posedge clk); #1; w++; end
    force_low = 1;
    dv = '{5, 5, 5, 5}; av = '{-1, -1, -1, -1}; kv = '{0, 0, 0, 0};
    run_class(dv, av, kv, 3, 4, 0, 1);
    w = 0;
    while (!result_valid && w < 50) begin @(posedge clk); #1; w++; end
    if (!result_valid) fail_now("bp_result_valid");
    for (int i = 0; i < 5; i++) begin
      dot_valid = 1; dot_in = 64'($urandom); alpha_in = 32'($urandom); kernel_sel = 1'($urandom);
      @(negedge clk);
      chk("bp_dot_ready", dot_ready, 0);
      chk("bp_result_valid", result_valid, 1);
      chk("bp_decision", decision, -17);
      @(posedge clk); #1;
    end
    dot_valid = 0;
    force_low = 0;
    dv = '{1, 1, 1, 1}; av = '{1, 1, 1, 1}; kv = '{0, 0, 0, 0};
    run_class(dv, av, kv, 0, 4, 0, 1);

    dv = '{7, 9, 2, 2}; av = '{3, 3, 3, 3}; kv = '{1, 0, 1, 0};
    run_class(dv, av, kv, 11, 2, 0, 0);
    rst = 1;
    #1;
    chk("midrst_result_valid", result_valid, 0);
    chk("midrst_decision", decision, 0);
    chk("midrst_class_out", class_out, 1);
    chk("midrst_dot_ready", dot_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    dv = '{1, 2, 3, 4}; av = '{1, -1, 2, 1}; kv = '{0, 0, 0, 0};
    run_class(dv, av, kv, -5, 4, 0, 1);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 4; i++) begin
        dv[i] = (r % 3 == 0) ? {$urandom, $urandom} : longint'($signed(16'($urandom)));
        av[i] = (r % 2 == 0) ? int'($urandom) : int'($signed(8'($urandom)));
        kv[i] = 1'($urandom);
      end
      run_class(dv, av, kv, {$urandom, $urandom}, 4, 3, 1);
    end

    w = 0;
    while ((expq.size() != 0 || result_valid) && w < 500) begin @(posedge clk); #1; w++; end
    if (expq.size() != 0) fail_now("drain_scoreboard");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
